// File: rtl/complete_cdb_arbiter.sv
// complete_cdb_arbiter: completion stage between the FU cluster and the CDB.
// Each FU owns a 2-entry result FIFO. A round-robin arbiter selects one FIFO
// head per cycle and loads it into registered CDB outputs. FIFO-full
// backpressure is decoded from registered state only.
module complete_cdb_arbiter #(
  parameter int NUM_FU = 6,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 5
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       squash,
  input  logic [NUM_FU-1:0]          fu_valid,
  input  logic [NUM_FU*TAG_W-1:0]    fu_tag,
  input  logic [NUM_FU*DATA_W-1:0]   fu_value,
  input  logic [NUM_FU*ROB_W-1:0]    fu_rob_idx,
  output logic [NUM_FU-1:0]          fu_stall,
  output logic                       cdb_valid,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [DATA_W-1:0]          cdb_value,
  output logic [ROB_W-1:0]           cdb_rob_idx,
  output logic [2:0]                 cdb_fu_id,
  output logic [3:0]                 pending_count,
  output logic                       overflow_err
);

  // FIFO control state (reset) and payload storage (not reset)
  logic [1:0]        r_cnt      [NUM_FU];
  logic              r_head     [NUM_FU];
  logic              r_tail     [NUM_FU];
  logic [TAG_W-1:0]  r_tag_mem  [NUM_FU][2];
  logic [DATA_W-1:0] r_val_mem  [NUM_FU][2];
  logic [ROB_W-1:0]  r_rob_mem  [NUM_FU][2];
  logic [2:0]        r_rr_ptr;

  logic [NUM_FU-1:0] w_nonempty;
  logic [NUM_FU-1:0] w_push;
  logic [NUM_FU-1:0] w_pop;
  logic [NUM_FU-1:0] w_ovf_hit;
  logic              w_gnt;
  logic [2:0]        w_gid;
  logic [2:0]        w_idx;
  logic [TAG_W-1:0]  w_hd_tag;
  logic [DATA_W-1:0] w_hd_val;
  logic [ROB_W-1:0]  w_hd_rob;
  logic [3:0]        w_sum;

  // Status decode from registered counts: emptiness, full stall, total pending
  always_comb begin
    w_sum = 4'd0;
    for (int i = 0; i < NUM_FU; i++) begin
      w_nonempty[i] = (r_cnt[i] != 2'd0);
      fu_stall[i]   = (r_cnt[i] == 2'd2);
      w_sum         = w_sum + 4'(r_cnt[i]);
    end
    pending_count = w_sum;
  end

  // Round-robin search starting at r_rr_ptr; scanning from the far end lets the
  // closest non-empty FIFO overwrite earlier candidates
  always_comb begin
    w_gnt = 1'b0;
    w_gid = 3'd0;
    w_idx = 3'd0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      w_idx = 3'((int'(r_rr_ptr) + k) % NUM_FU);
      if (w_nonempty[w_idx]) begin
        w_gnt = 1'b1;
        w_gid = w_idx;
      end
    end
  end

  // Head-of-FIFO mux for the granted FU
  always_comb begin
    w_hd_tag = '0;
    w_hd_val = '0;
    w_hd_rob = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_gid == 3'(i)) begin
        w_hd_tag = r_tag_mem[i][r_head[i]];
        w_hd_val = r_val_mem[i][r_head[i]];
        w_hd_rob = r_rob_mem[i][r_head[i]];
      end
    end
  end

  // Push/pop qualification; a full FIFO rejects pushes even when popped this cycle
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      w_push[i]    = fu_valid[i] && (r_cnt[i] != 2'd2) && !squash;
      w_ovf_hit[i] = fu_valid[i] && (r_cnt[i] == 2'd2) && !squash;
      w_pop[i]     = w_gnt && !squash && (w_gid == 3'(i));
    end
  end

  // FIFO pointers and occupancy; squash empties every FIFO
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        r_cnt[i]  <= 2'd0;
        r_head[i] <= 1'b0;
        r_tail[i] <= 1'b0;
      end
    end else if (squash) begin
      for (int i = 0; i < NUM_FU; i++) begin
        r_cnt[i]  <= 2'd0;
        r_head[i] <= 1'b0;
        r_tail[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_push[i]) r_tail[i] <= ~r_tail[i];
        if (w_pop[i])  r_head[i] <= ~r_head[i];
        r_cnt[i] <= r_cnt[i] + {1'b0, w_push[i]} - {1'b0, w_pop[i]};
      end
    end
  end

  // FIFO payload write at the tail slot
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (w_push[i]) begin
        r_tag_mem[i][r_tail[i]] <= fu_tag[i*TAG_W +: TAG_W];
        r_val_mem[i][r_tail[i]] <= fu_value[i*DATA_W +: DATA_W];
        r_rob_mem[i][r_tail[i]] <= fu_rob_idx[i*ROB_W +: ROB_W];
      end
    end
  end

  // Registered CDB broadcast; fields hold when nothing is granted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cdb_valid   <= 1'b0;
      cdb_tag     <= '0;
      cdb_value   <= '0;
      cdb_rob_idx <= '0;
      cdb_fu_id   <= 3'd0;
    end else if (w_gnt && !squash) begin
      cdb_valid   <= 1'b1;
      cdb_tag     <= w_hd_tag;
      cdb_value   <= w_hd_val;
      cdb_rob_idx <= w_hd_rob;
      cdb_fu_id   <= w_gid;
    end else begin
      cdb_valid   <= 1'b0;
    end
  end

  // Round-robin pointer advances past the granted FU; squash leaves it alone
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rr_ptr <= 3'd0;
    end else if (w_gnt && !squash) begin
      r_rr_ptr <= (w_gid == 3'(NUM_FU - 1)) ? 3'd0 : w_gid + 3'd1;
    end
  end

  // Sticky overflow flag on any push into a full FIFO
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_err <= 1'b0;
    end else if (|w_ovf_hit) begin
      overflow_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_complete_cdb_arbiter.sv
// Scoreboard bench for complete_cdb_arbiter: a transaction-level model queues the
// expected CDB entries per edge; each DUT pulse pops and compares one.
module tb_complete_cdb_arbiter;
  localparam int NUM_FU = 6;
  localparam int TAG_W  = 6;
  localparam int DATA_W = 32;
  localparam int ROB_W  = 5;

  logic                     clock = 1'b0;
  logic                     reset;
  logic                     squash;
  logic [NUM_FU-1:0]        fu_valid;
  logic [NUM_FU*TAG_W-1:0]  fu_tag;
  logic [NUM_FU*DATA_W-1:0] fu_value;
  logic [NUM_FU*ROB_W-1:0]  fu_rob_idx;
  logic [NUM_FU-1:0]        fu_stall;
  logic                     cdb_valid;
  logic [TAG_W-1:0]         cdb_tag;
  logic [DATA_W-1:0]        cdb_value;
  logic [ROB_W-1:0]         cdb_rob_idx;
  logic [2:0]               cdb_fu_id;
  logic [3:0]               pending_count;
  logic                     overflow_err;

  complete_cdb_arbiter #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .DATA_W(DATA_W), .ROB_W(ROB_W)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_value(fu_value), .fu_rob_idx(fu_rob_idx),
    .fu_stall(fu_stall), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_rob_idx(cdb_rob_idx), .cdb_fu_id(cdb_fu_id), .pending_count(pending_count),
    .overflow_err(overflow_err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
    logic [ROB_W-1:0]  rob;
    logic [2:0]        fid;
  } ent_t;

  ent_t m_e   [NUM_FU][2];
  int   m_cnt [NUM_FU];
  int   m_rr;
  logic m_ovf;
  logic m_gv;
  ent_t exp_q [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, req, $time);
    end
  endtask

  task automatic drive_fu(input int i, input logic [TAG_W-1:0] tag,
                          input logic [DATA_W-1:0] val, input logic [ROB_W-1:0] rob);
    fu_valid[i]                    = 1'b1;
    fu_tag[i*TAG_W +: TAG_W]       = tag;
    fu_value[i*DATA_W +: DATA_W]   = val;
    fu_rob_idx[i*ROB_W +: ROB_W]   = rob;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_FU; i++) m_cnt[i] = 0;
    m_rr  = 0;
    m_ovf = 1'b0;
    m_gv  = 1'b0;
    exp_q.delete();
  endtask

  // Model one clock edge using the inputs presented during the cycle
  task automatic model_edge();
    int   sz [NUM_FU];
    int   g;
    int   idx;
    bit   found;
    ent_t e;
    for (int i = 0; i < NUM_FU; i++) sz[i] = m_cnt[i];
    m_gv  = 1'b0;
    found = 1'b0;
    g     = 0;
    if (squash) begin
      for (int i = 0; i < NUM_FU; i++) m_cnt[i] = 0;
    end else begin
      for (int k = 0; k < NUM_FU; k++) begin
        idx = (m_rr + k) % NUM_FU;
        if (!found && sz[idx] > 0) begin
          found = 1'b1;
          g     = idx;
        end
      end
      if (found) begin
        e     = m_e[g][0];
        e.fid = 3'(g);
        exp_q.push_back(e);
        m_e[g][0] = m_e[g][1];
        m_cnt[g]--;
        m_rr = (g + 1) % NUM_FU;
        m_gv = 1'b1;
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i]) begin
          if (sz[i] == 2) begin
            m_ovf = 1'b1;
          end else begin
            e.tag = fu_tag[i*TAG_W +: TAG_W];
            e.val = fu_value[i*DATA_W +: DATA_W];
            e.rob = fu_rob_idx[i*ROB_W +: ROB_W];
            e.fid = 3'd0;
            m_e[i][m_cnt[i]] = e;
            m_cnt[i]++;
          end
        end
      end
    end
  endtask

  task automatic compare();
    ent_t       e;
    int         sum;
    logic [5:0] es;
    sum = 0;
    for (int i = 0; i < NUM_FU; i++) begin
      sum   = sum + m_cnt[i];
      es[i] = (m_cnt[i] == 2);
    end
    chk("cdb_valid", 64'(cdb_valid), 64'(m_gv));
    if (cdb_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("cdb_unexpected", 64'(cdb_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("cdb_tag",   64'(cdb_tag),     64'(e.tag));
        chk("cdb_value", 64'(cdb_value),   64'(e.val));
        chk("cdb_rob",   64'(cdb_rob_idx), 64'(e.rob));
        chk("cdb_fu_id", 64'(cdb_fu_id),   64'(e.fid));
      end
    end
    chk("pending_count", 64'(pending_count), 64'(sum));
    chk("fu_stall",      64'(fu_stall),      64'(es));
    chk("overflow_err",  64'(overflow_err),  64'(m_ovf));
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int n2;
    reset      = 1'b1;
    squash     = 1'b0;
    fu_valid   = '0;
    fu_tag     = '0;
    fu_value   = '0;
    fu_rob_idx = '0;
    model_reset();
    @(posedge clock);
    #1;
    chk("rst_valid",   64'(cdb_valid),     64'(0));
    chk("rst_tag",     64'(cdb_tag),       64'(0));
    chk("rst_value",   64'(cdb_value),     64'(0));
    chk("rst_rob",     64'(cdb_rob_idx),   64'(0));
    chk("rst_fu_id",   64'(cdb_fu_id),     64'(0));
    chk("rst_pending", 64'(pending_count), 64'(0));
    chk("rst_stall",   64'(fu_stall),      64'(0));
    chk("rst_ovf",     64'(overflow_err),  64'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;

    // Test 1: single result from FU 0
    drive_fu(0, 6'd5, 32'hDEAD, 5'd3);
    step();
    chk("t1_pend1",  64'(pending_count), 64'(1));
    chk("t1_nobyp",  64'(cdb_valid),     64'(0));
    fu_valid = '0;
    step();
    chk("t1_valid",  64'(cdb_valid),     64'(1));
    chk("t1_tag",    64'(cdb_tag),       64'(5));
    chk("t1_value",  64'(cdb_value),     64'(32'hDEAD));
    chk("t1_rob",    64'(cdb_rob_idx),   64'(3));
    chk("t1_fid",    64'(cdb_fu_id),     64'(0));
    chk("t1_pend0",  64'(pending_count), 64'(0));
    step();
    chk("t1_pulse",  64'(cdb_valid),     64'(0));

    // Test 2: all FUs push together from a fresh round-robin pointer
    do_reset();
    for (int i = 0; i < NUM_FU; i++) drive_fu(i, 6'(i), 32'h100 + 32'(i), 5'(i));
    step();
    chk("t2_pend6", 64'(pending_count), 64'(6));
    fu_valid = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      step();
      chk("t2_valid", 64'(cdb_valid),     64'(1));
      chk("t2_fid",   64'(cdb_fu_id),     64'(k));
      chk("t2_tag",   64'(cdb_tag),       64'(k));
      chk("t2_pend",  64'(pending_count), 64'(5 - k));
      chk("t2_stall", 64'(fu_stall),      64'(0));
    end
    step();

    // Test 3: FU 5 streams one result per cycle
    for (int c = 0; c < 4; c++) begin
      fu_valid = '0;
      drive_fu(5, 6'(20 + c), 32'h500 + 32'(c), 5'(c));
      step();
      chk("t3_stall5", 64'(fu_stall[5]), 64'(0));
    end
    fu_valid = '0;
    repeat (3) step();

    // Test 4: all FUs busy until FIFO 2 is full, then overflow it
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < NUM_FU; i++)
        drive_fu(i, 6'(c * 8 + i), 32'(c * 256 + i), 5'(c * 6 + i));
      step();
      if (c == 1) chk("t4_stall2", 64'(fu_stall[2]), 64'(1));
    end
    chk("t4_ovf", 64'(overflow_err), 64'(1));
    fu_valid = '0;
    n2 = 0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (cdb_valid === 1'b1 && cdb_fu_id == 3'd2) begin
        chk("t4_fifo2_tag", 64'(cdb_tag), (n2 == 0) ? 64'(2) : 64'(10));
        n2++;
      end
    end
    chk("t4_fifo2_cnt", 64'(n2), 64'(2));
    chk("t4_drained",   64'(pending_count), 64'(0));

    // Test 5: squash with five pending entries and a same-cycle push
    for (int i = 0; i < 5; i++) drive_fu(i, 6'(40 + i), 32'h4000 + 32'(i), 5'(i));
    step();
    chk("t5_pend5", 64'(pending_count), 64'(5));
    fu_valid = '0;
    squash   = 1'b1;
    drive_fu(5, 6'd50, 32'h5050, 5'd9);
    step();
    squash   = 1'b0;
    fu_valid = '0;
    chk("t5_pend0",  64'(pending_count), 64'(0));
    chk("t5_valid0", 64'(cdb_valid),     64'(0));
    chk("t5_stall0", 64'(fu_stall),      64'(0));
    chk("t5_ovf",    64'(overflow_err),  64'(1));
    step();
    chk("t5_quiet",  64'(cdb_valid),     64'(0));
    drive_fu(3, 6'd33, 32'h3333, 5'd7);
    step();
    fu_valid = '0;
    step();
    chk("t5_valid", 64'(cdb_valid), 64'(1));
    chk("t5_fid",   64'(cdb_fu_id), 64'(3));
    chk("t5_tag",   64'(cdb_tag),   64'(33));
    chk("t5_value", 64'(cdb_value), 64'(32'h3333));

    // Test 6: asynchronous reset in the middle of a burst
    for (int i = 0; i < NUM_FU; i++) drive_fu(i, 6'(i + 1), 32'h6000 + 32'(i), 5'(i + 1));
    step();
    fu_valid = '0;
    step();
    chk("t6_pre_valid", 64'(cdb_valid), 64'(1));
    #2;
    reset = 1'b1;
    #1;
    chk("t6_valid", 64'(cdb_valid),     64'(0));
    chk("t6_pend",  64'(pending_count), 64'(0));
    chk("t6_stall", 64'(fu_stall),      64'(0));
    chk("t6_ovf",   64'(overflow_err),  64'(0));
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t6_quiet", 64'(cdb_valid), 64'(0));
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
